// File: rtl/ft_pkg.sv
// Shared types and field-mask bit positions for the lockstep monitor.
package ft_pkg;

    localparam int unsigned FT_FIELD_W = 3;

    localparam int unsigned FT_F_IADDR = 0;
    localparam int unsigned FT_F_DADDR = 1;
    localparam int unsigned FT_F_WDATA = 2;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        REQ,
        WAIT,
        FAULT
    } ft_mon_state_e;

endpackage

// File: rtl/ft_lockstep_cmp.sv
// Combinational comparison of the two core buses into a per-field mismatch mask.
module ft_lockstep_cmp
    import ft_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]     c0_instr_addr,
    input  logic [DATA_W-1:0]     c1_instr_addr,
    input  logic                  c0_data_req,
    input  logic                  c1_data_req,
    input  logic                  c0_data_we,
    input  logic                  c1_data_we,
    input  logic [DATA_W-1:0]     c0_data_addr,
    input  logic [DATA_W-1:0]     c1_data_addr,
    input  logic [DATA_W-1:0]     c0_data_wdata,
    input  logic [DATA_W-1:0]     c1_data_wdata,
    output logic [FT_FIELD_W-1:0] mask_c
);

    logic both_req;

    // Address/we are only meaningful when both cores issue a request; wdata only on writes.
    always_comb begin
        mask_c   = '0;
        both_req = c0_data_req & c1_data_req;
        mask_c[FT_F_IADDR] = (c0_instr_addr != c1_instr_addr);
        mask_c[FT_F_DADDR] = (c0_data_req != c1_data_req) ||
                             (both_req && ((c0_data_we != c1_data_we) ||
                                           (c0_data_addr != c1_data_addr)));
        mask_c[FT_F_WDATA] = both_req && c0_data_we && c1_data_we &&
                             (c0_data_wdata != c1_data_wdata);
    end

endmodule

// File: rtl/ft_lockstep_monitor.sv
// Lockstep divergence detector with halt/recovery handshake and retry escalation.
module ft_lockstep_monitor
    import ft_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned RECOVERY_CYCLES = 8,
    parameter int unsigned CLEAN_CYCLES    = 64,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [DATA_W-1:0]     c0_instr_addr_i,
    input  logic [DATA_W-1:0]     c1_instr_addr_i,
    input  logic                  c0_data_req_i,
    input  logic                  c1_data_req_i,
    input  logic                  c0_data_we_i,
    input  logic                  c1_data_we_i,
    input  logic [DATA_W-1:0]     c0_data_addr_i,
    input  logic [DATA_W-1:0]     c1_data_addr_i,
    input  logic [DATA_W-1:0]     c0_data_wdata_i,
    input  logic [DATA_W-1:0]     c1_data_wdata_i,
    input  logic                  recover_ack_i,
    output logic                  error_o,
    output logic                  halt_o,
    output logic                  recover_req_o,
    output logic                  fault_o,
    output logic [CNT_W-1:0]      err_count_o,
    output logic [DATA_W-1:0]     err_addr_o,
    output logic [FT_FIELD_W-1:0] err_field_o
);

    localparam int unsigned CLEAN_W = $clog2(CLEAN_CYCLES + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned WAIT_W  = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;

    localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLEAN_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(RECOVERY_CYCLES - 1);

    ft_mon_state_e          state;
    logic [FT_FIELD_W-1:0]  field_mask;
    logic                   mismatch;
    logic [CLEAN_W-1:0]     clean_cnt;
    logic [RETRY_W-1:0]     retry_cnt;
    logic [WAIT_W-1:0]      wait_cnt;

    ft_lockstep_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .c0_instr_addr (c0_instr_addr_i),
        .c1_instr_addr (c1_instr_addr_i),
        .c0_data_req   (c0_data_req_i),
        .c1_data_req   (c1_data_req_i),
        .c0_data_we    (c0_data_we_i),
        .c1_data_we    (c1_data_we_i),
        .c0_data_addr  (c0_data_addr_i),
        .c1_data_addr  (c1_data_addr_i),
        .c0_data_wdata (c0_data_wdata_i),
        .c1_data_wdata (c1_data_wdata_i),
        .mask_c        (field_mask)
    );

    assign mismatch = |field_mask;

    // Sequencer, counters and capture; halt/req/fault are updated alongside each transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            error_o       <= 1'b0;
            halt_o        <= 1'b0;
            recover_req_o <= 1'b0;
            fault_o       <= 1'b0;
            err_count_o   <= '0;
            err_addr_o    <= '0;
            err_field_o   <= '0;
            clean_cnt     <= '0;
            retry_cnt     <= '0;
            wait_cnt      <= '0;
        end else if (clear_i) begin
            state         <= IDLE;
            error_o       <= 1'b0;
            halt_o        <= 1'b0;
            recover_req_o <= 1'b0;
            fault_o       <= 1'b0;
            err_count_o   <= '0;
            err_addr_o    <= '0;
            err_field_o   <= '0;
            clean_cnt     <= '0;
            retry_cnt     <= '0;
            wait_cnt      <= '0;
        end else begin
            error_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end else if (mismatch) begin
                        error_o     <= 1'b1;
                        err_addr_o  <= c0_instr_addr_i;
                        err_field_o <= field_mask;
                        clean_cnt   <= '0;
                        retry_cnt   <= retry_cnt + RETRY_W'(1);
                        halt_o      <= 1'b1;
                        if (err_count_o != '1) begin
                            err_count_o <= err_count_o + CNT_W'(1);
                        end
                        if (retry_cnt == RETRY_LAST) begin
                            state   <= FAULT;
                            fault_o <= 1'b1;
                        end else begin
                            state         <= REQ;
                            recover_req_o <= 1'b1;
                        end
                    end else if (clean_cnt == CLEAN_LAST) begin
                        // A full clean window forgives earlier detections.
                        clean_cnt <= '0;
                        retry_cnt <= '0;
                    end else begin
                        clean_cnt <= clean_cnt + CLEAN_W'(1);
                    end
                end
                REQ: begin
                    if (recover_ack_i) begin
                        state         <= WAIT;
                        recover_req_o <= 1'b0;
                        wait_cnt      <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state  <= COMPARE;
                        halt_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_lockstep_monitor.sv
// Randomized and directed checks of ft_lockstep_monitor against a behavioural model.
module tb_ft_lockstep_monitor;

    localparam int unsigned DW    = 32;
    localparam int unsigned REC   = 8;
    localparam int unsigned CLEAN = 64;
    localparam int unsigned MAXR  = 3;

    logic          clk = 1'b0;
    logic          rst, enable, clear, ack;
    logic [DW-1:0] c0_ia, c1_ia, c0_da, c1_da, c0_wd, c1_wd;
    logic          c0_req, c1_req, c0_we, c1_we;

    logic          error, halt, rreq, fault;
    logic [15:0]   count;
    logic [DW-1:0] eaddr;
    logic [2:0]    efield;
    logic          s_error, s_halt, s_rreq, s_fault;
    logic [1:0]    s_count;
    logic [DW-1:0] s_eaddr;
    logic [2:0]    s_efield;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase flags, remaining wait time and plain-integer counters.
    bit          m_cmp, m_req, m_fault, m_err;
    int          m_wait_left, m_retries, m_clean;
    int unsigned m_count;
    logic [DW-1:0] m_addr;
    logic [2:0]    m_field;

    always #5 clk = ~clk;

    ft_lockstep_monitor dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .c0_instr_addr_i(c0_ia), .c1_instr_addr_i(c1_ia),
        .c0_data_req_i(c0_req), .c1_data_req_i(c1_req),
        .c0_data_we_i(c0_we), .c1_data_we_i(c1_we),
        .c0_data_addr_i(c0_da), .c1_data_addr_i(c1_da),
        .c0_data_wdata_i(c0_wd), .c1_data_wdata_i(c1_wd),
        .recover_ack_i(ack),
        .error_o(error), .halt_o(halt), .recover_req_o(rreq), .fault_o(fault),
        .err_count_o(count), .err_addr_o(eaddr), .err_field_o(efield)
    );

    ft_lockstep_monitor #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .c0_instr_addr_i(c0_ia), .c1_instr_addr_i(c1_ia),
        .c0_data_req_i(c0_req), .c1_data_req_i(c1_req),
        .c0_data_we_i(c0_we), .c1_data_we_i(c1_we),
        .c0_data_addr_i(c0_da), .c1_data_addr_i(c1_da),
        .c0_data_wdata_i(c0_wd), .c1_data_wdata_i(c1_wd),
        .recover_ack_i(ack),
        .error_o(s_error), .halt_o(s_halt), .recover_req_o(s_rreq), .fault_o(s_fault),
        .err_count_o(s_count), .err_addr_o(s_eaddr), .err_field_o(s_efield)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_mask();
        logic [2:0] m;
        m = 3'b000;
        if (c0_ia != c1_ia) m[0] = 1'b1;
        if (c0_req != c1_req) m[1] = 1'b1;
        else if (c0_req && ((c0_we != c1_we) || (c0_da != c1_da))) m[1] = 1'b1;
        if (c0_req && c1_req && c0_we && c1_we && (c0_wd != c1_wd)) m[2] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_cmp = 0; m_req = 0; m_fault = 0; m_err = 0;
        m_wait_left = 0; m_retries = 0; m_clean = 0;
        m_count = 0; m_addr = '0; m_field = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [2:0] mk;
        mk = ref_mask();
        if (rst) begin
            model_reset();
        end else if (clear) begin
            model_reset();
        end else begin
            m_err = 0;
            if (m_fault) begin
                m_fault = 1;
            end else if (m_req) begin
                if (ack) begin
                    m_req = 0;
                    m_wait_left = REC;
                end
            end else if (m_wait_left > 0) begin
                m_wait_left--;
                if (m_wait_left == 0) m_cmp = 1;
            end else if (m_cmp) begin
                if (!enable) begin
                    m_cmp = 0;
                end else if (mk != 3'b000) begin
                    m_err = 1;
                    m_count++;
                    m_addr = c0_ia;
                    m_field = mk;
                    m_clean = 0;
                    m_retries++;
                    m_cmp = 0;
                    if (m_retries >= MAXR) m_fault = 1;
                    else m_req = 1;
                end else begin
                    m_clean++;
                    if (m_clean == CLEAN) begin
                        m_clean = 0;
                        m_retries = 0;
                    end
                end
            end else if (enable) begin
                m_cmp = 1;
            end
        end
    endtask

    task automatic check_all();
        bit halt_exp;
        halt_exp = m_req || (m_wait_left > 0) || m_fault;
        check("error", error, m_err);
        check("halt", halt, halt_exp);
        check("recover_req", rreq, m_req);
        check("fault", fault, m_fault);
        check("err_count", count, (m_count > 65535) ? 65535 : m_count);
        check("err_addr", eaddr, m_addr);
        check("err_field", efield, m_field);
        check("sat_count", s_count, (m_count > 3) ? 3 : m_count);
        check("sat_halt", s_halt, halt_exp);
        check("sat_misc", {s_error, s_rreq, s_fault, s_efield},
              {m_err, m_req, m_fault, m_field});
        check("sat_addr", s_eaddr, m_addr);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Random identical buses, with optional per-field divergence injected on core 1.
    task automatic set_bus(input logic [2:0] inj);
        c0_ia = $urandom; c0_da = $urandom; c0_wd = $urandom;
        c0_req = 1'($urandom_range(1, 0)); c0_we = 1'($urandom_range(1, 0));
        c1_ia = c0_ia; c1_da = c0_da; c1_wd = c0_wd; c1_req = c0_req; c1_we = c0_we;
        if (inj[2]) begin
            c0_req = 1; c1_req = 1; c0_we = 1; c1_we = 1;
            c1_wd = c1_wd ^ (32'h1 << $urandom_range(31, 0));
        end
        if (inj[1]) begin
            if ($urandom_range(1, 0) == 1) begin
                c1_req = ~c1_req;
            end else begin
                c0_req = 1; c1_req = 1;
                c1_da = c1_da ^ (32'h1 << $urandom_range(31, 0));
            end
        end
        if (inj[0]) c1_ia = c1_ia ^ (32'h1 << $urandom_range(31, 0));
    endtask

    task automatic clean(input int n);
        repeat (n) begin
            set_bus(3'b000);
            tick();
        end
    endtask

    task automatic inject();
        set_bus(3'($urandom_range(7, 1)));
        tick();
        set_bus(3'b000);
    endtask

    task automatic recover();
        ack = 1;
        tick();
        ack = 0;
        repeat (REC) tick();
    endtask

    initial begin
        rst = 1; enable = 0; clear = 0; ack = 0;
        model_reset();
        set_bus(3'b000);
        tick();
        tick();
        check("rst_halt", halt, 1'b0);
        check("rst_count", count, 16'd0);
        rst = 0;

        // Matched traffic
        enable = 1;
        clean(200);
        check("match_count", count, 16'd0);
        check("match_halt", halt, 1'b0);

        // Single wdata mismatch then recovery timing
        set_bus(3'b000);
        c0_ia = 32'h40; c1_ia = 32'h40;
        c0_req = 1; c1_req = 1; c0_we = 1; c1_we = 1;
        c0_wd = 32'hDEAD0000; c1_wd = 32'hDEAD0001;
        tick();
        check("wd_error", error, 1'b1);
        check("wd_field", efield, 3'b100);
        check("wd_addr", eaddr, 32'h40);
        check("wd_count", count, 16'd1);
        check("wd_halt", halt, 1'b1);
        check("wd_req", rreq, 1'b1);
        clean(3);
        ack = 1;
        tick();
        ack = 0;
        clean(REC - 1);
        check("wd_halt_wait", halt, 1'b1);
        clean(1);
        check("wd_halt_fall", halt, 1'b0);

        // Escalation
        clear = 1; tick(); clear = 0;
        clean(1);
        for (int i = 0; i < 3; i++) begin
            inject();
            if (i < 2) begin
                recover();
                clean(5);
            end
        end
        check("esc_fault", fault, 1'b1);
        check("esc_halt", halt, 1'b1);
        ack = 1;
        clean(3);
        ack = 0;
        check("esc_ack_fault", fault, 1'b1);
        check("esc_ack_halt", halt, 1'b1);
        clear = 1; tick(); clear = 0;
        check("esc_clr_fault", fault, 1'b0);
        check("esc_clr_count", count, 16'd0);
        check("esc_clr_field", efield, 3'b000);
        check("esc_clr_addr", eaddr, 32'h0);

        // Clean window
        clean(1);
        inject(); recover(); clean(3);
        inject(); recover(); clean(CLEAN);
        inject();
        check("cw_req", rreq, 1'b1);
        check("cw_fault", fault, 1'b0);
        check("cw_count", count, 16'd3);
        recover(); clean(CLEAN);
        inject();
        check("cw_sat", s_count, 2'd3);
        check("cw_count4", count, 16'd4);
        recover();

        // Priority: clear vs mismatch, reset during WAIT
        set_bus(3'b100);
        clear = 1; tick(); clear = 0;
        check("pri_error", error, 1'b0);
        check("pri_count", count, 16'd0);
        set_bus(3'b000);
        clean(1);
        inject();
        ack = 1; tick(); ack = 0;
        clean(3);
        rst = 1; tick(); rst = 0;
        check("rst_wait_halt", halt, 1'b0);
        check("rst_wait_error", error, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(399, 0) == 0);
            clear  = ($urandom_range(299, 0) == 0);
            enable = ($urandom_range(9, 0) != 0);
            ack    = ($urandom_range(9, 0) < 3);
            if ($urandom_range(99, 0) < 4) set_bus(3'($urandom_range(7, 1)));
            else set_bus(3'b000);
            tick();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/ft_lockstep_monitor.md
# ft_lockstep_monitor

Synthesizable error detector and recovery sequencer for the dual-core lockstep pair in `cevero_soc`. Each cycle it compares the bus outputs of `core_0` and `core_1` and flags any divergence with a one-cycle `error_o` pulse. It captures diagnostic state and drives a halt/recovery handshake toward the core wrapper. Repeated errors without a clean interval escalate to a sticky unrecoverable fault. It is the hardware consumer of the faults that fault-injection benches force onto the core buses.

## Interface
- `DATA_W`, 32: width of address and data buses.
- `CNT_W`, 16: width of the error counter.
- `RECOVERY_CYCLES`, 8: cycles the cores stay halted after `recover_ack_i`; must be ≥1.
- `CLEAN_CYCLES`, 64: consecutive mismatch-free COMPARE cycles that reset the retry count.
- `MAX_RETRIES`, 3: detection number at which the block enters FAULT.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `enable_i` in 1: start and continue comparison.
- `clear_i` in 1: clear diagnostics and exit FAULT.
- `c0_instr_addr_i`, `c1_instr_addr_i` in DATA_W: instruction fetch addresses.
- `c0_data_req_i`, `c1_data_req_i` in 1: data requests.
- `c0_data_we_i`, `c1_data_we_i` in 1: write enables.
- `c0_data_addr_i`, `c1_data_addr_i` in DATA_W: data addresses.
- `c0_data_wdata_i`, `c1_data_wdata_i` in DATA_W: write data.
- `recover_ack_i` in 1: core wrapper has restored its state.
- `error_o` out 1: one-cycle pulse per detection.
- `halt_o` out 1: stall both cores.
- `recover_req_o` out 1: request rollback or restore.
- `fault_o` out 1: sticky unrecoverable fault.
- `err_count_o` out CNT_W: saturating count of detections.
- `err_addr_o` out DATA_W: `c0_instr_addr_i` at the last detection.
- `err_field_o` out 3: mismatch mask at the last detection; bit0 instr_addr, bit1 data request/address, bit2 wdata.

## Operation
- **Reset values:** all outputs 0; state IDLE; internal counters 0.
- **Field comparison:**
  - bit0 is set when the two instruction addresses differ.
  - bit1 is set when the `req` signals differ, or when both `req` are 1 and either `we` or `addr` differs.
  - bit2 is set when `req` and `we` are 1 on both cores and `wdata` differs.
  - A mismatch is any nonzero mask.
- **IDLE:** no comparison. Goes to COMPARE when `enable_i` is 1.
- **COMPARE:**
  - `enable_i` = 0 → IDLE.
  - A mismatch triggers a detection at that edge:
    - `error_o` goes to 1 for the next cycle.
    - `err_count_o` increments, saturating at all-ones.
    - `err_addr_o` and `err_field_o` are captured.
    - The retry count increments. If it reaches MAX_RETRIES → FAULT, otherwise → REQ.
  - Without a mismatch, the clean counter increments. When it reaches CLEAN_CYCLES, the retry count and the clean counter both reset to 0.
  - Any detection also resets the clean counter.
- **REQ:** `halt_o` = 1 and `recover_req_o` = 1. Leaves on the edge where `recover_ack_i` is 1 → WAIT.
- **WAIT:** `halt_o` = 1 and `recover_req_o` = 0. Comparison is masked. After RECOVERY_CYCLES cycles → COMPARE.
- **FAULT:** `halt_o` = 1 and `fault_o` = 1. Comparison is masked. Exits only via `rst_i` or `clear_i`.
- **`clear_i`:** zeroes the count, `err_addr_o`, `err_field_o`, the retry count and the clean counter, and sends the block to IDLE from any state.
  - It overrides a simultaneous mismatch: no `error_o` pulse and no capture.
  - `rst_i` overrides `clear_i`.
- **`enable_i` in REQ/WAIT/FAULT:** ignored; a recovery in progress always completes.
- **`recover_ack_i` outside REQ:** ignored.

## Timing
- All outputs are registered. Detection latency is 1 cycle: a mismatch sampled at edge k gives `error_o` and updated diagnostics in cycle k+1.
- `halt_o` rises in cycle k+1 (REQ or FAULT). `fault_o` also rises in cycle k+1 when the detection is the escalating one.
- **Recovery:** with `recover_ack_i` sampled at edge a, `halt_o` falls in cycle a+RECOVERY_CYCLES+1 and comparison resumes at that edge.
- `error_o` is never high for two consecutive cycles.
- `rst_i` takes effect on the same edge, including mid-recovery: outputs are 0 the following cycle.

## Structure
- Package `ft_pkg` holds:
  - `ft_mon_state_e` {IDLE, COMPARE, REQ, WAIT, FAULT};
  - field-mask bit constants `FT_F_IADDR`, `FT_F_DADDR`, `FT_F_WDATA`.
- Sub-module `ft_lockstep_cmp` is purely combinational and produces the 3-bit mask. The parent holds the FSM, counters and capture registers.

## Test plan
- **Matched traffic:** drive identical core buses for 200 cycles with `enable_i`=1 → `error_o` never asserts, `err_count_o`=0, `halt_o`=0.
- **Single wdata mismatch:**
  - Stimulus: `c1_data_wdata_i`=0xDEAD0001 vs 0xDEAD0000, both `req`/`we`=1, at edge 10, with `c0_instr_addr_i`=0x40.
  - Response in cycle 11: `error_o`=1, `err_field_o`=3'b100, `err_addr_o`=0x40, `err_count_o`=1, `halt_o`=1, `recover_req_o`=1.
  - Ack at edge 15: `halt_o`=0 from cycle 24.
- **Escalation:** three mismatches, each after completed recovery and fewer than 64 clean cycles apart → the third gives `fault_o`=1 with `halt_o` stuck at 1. `recover_ack_i` has no effect; `clear_i` → IDLE with all diagnostics 0.
- **Clean window:**
  - Two mismatches, then 64 clean cycles, then a third → REQ, not FAULT; `err_count_o`=3.
  - With `CNT_W`=2, a fourth detection (after ≥64 clean cycles) leaves `err_count_o` saturated at 3.
- **Priority:** `clear_i` and a mismatch on the same edge → no `error_o`, counters 0. `rst_i` asserted during WAIT → all outputs 0 the next cycle, state IDLE.
